// File: rtl/execon_gen.sv
// Execute-control sequencer: prefetch consumption, instruction execute, immediate
// extension writes and single-step halting. Define EXECON_STEPCNT_EN for a multi-step counter.
module execon_gen #(
   parameter int NWAIT = 3,
   parameter int IMMW  = 2,
   parameter int SCW   = 4
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             go,
   input  logic             insrdy,
   input  logic             immld,
   input  logic [1:0]       immcnt,
   input  logic [NWAIT-1:0] wait_req,
   input  logic             single_step,
   input  logic             single_go,
`ifdef EXECON_STEPCNT_EN
   input  logic [SCW-1:0]   step_cnt,
`endif
   output logic             romold,
   output logic             exe,
   output logic             insexe,
   output logic             immwri,
   output logic [1:0]       immidx,
   output logic             stop,
   output logic             idle,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_IMM  = 2'd2;
   localparam logic [1:0] S_STOP = 2'd3;
   localparam logic [1:0] IMM_MAX = 2'(IMMW - 1);

   if (NWAIT < 1 || NWAIT > 8 || IMMW < 1 || IMMW > 4 || SCW < 1 || SCW > 8) begin : g_param_chk
      $error("execon_gen: parameter out of range");
   end

   logic [1:0] state_q, state_d;
   logic       vins_q, vins_d;
   logic [1:0] rem_q, rem_d;
   logic [1:0] idx_q, idx_d;
   logic       godrop_q, godrop_d;
   logic       insexe_q;
   logic       step_done;
   logic [1:0] imm_clamp;

   assign imm_clamp = (immcnt > IMM_MAX) ? IMM_MAX : immcnt;

`ifdef EXECON_STEPCNT_EN
   logic [SCW-1:0] cnt_q, cnt_d;
   logic           complete;

   // A counter already drained to 0 behaves as the final step, so raising
   // single_step mid-run halts at the very next completion.
   assign step_done = single_step & (cnt_q <= SCW'(1));
   assign complete  = (exe & ~immld) | ((state_q == S_IMM) & insrdy & (rem_q == 2'd0));

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == S_STOP) && go && single_go)
         cnt_d = (step_cnt == '0) ? SCW'(1) : step_cnt;
      else if (complete && (cnt_q != '0))
         cnt_d = cnt_q - SCW'(1);
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign step_done = single_step;
`endif

   // go=0 takes priority over execution so a dropped run never retires a word.
   assign exe = (state_q == S_EXEC) & go & vins_q & ~|wait_req;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      idx_d    = idx_q;
      godrop_d = godrop_q;
      romold   = 1'b0;
      immwri   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) state_d = S_EXEC;
         end
         S_EXEC: begin
            romold = go & insrdy & (~vins_q | (exe & ~immld & ~step_done));
            if (!go) begin
               state_d = S_IDLE;
            end else if (exe && immld) begin
               state_d  = S_IMM;
               rem_d    = imm_clamp;
               idx_d    = 2'd0;
               godrop_d = 1'b0;
            end else if (exe && step_done) begin
               state_d = S_STOP;
            end
         end
         S_IMM: begin
            if (!go) godrop_d = 1'b1;
            if (insrdy) begin
               immwri = 1'b1;
               romold = 1'b1;
               idx_d  = idx_q + 2'd1;
               rem_d  = rem_q - 2'd1;
               if (rem_q == 2'd0) begin
                  idx_d    = 2'd0;
                  rem_d    = 2'd0;
                  godrop_d = 1'b0;
                  if (godrop_q || !go) state_d = S_IDLE;
                  else if (step_done)  state_d = S_STOP;
                  else                 state_d = S_EXEC;
               end
            end
         end
         S_STOP: begin
            if (!go) begin
               state_d = S_IDLE;
            end else if (single_go) begin
               state_d = S_EXEC;
               romold  = insrdy & ~vins_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Extension words consumed in IMM are operands, never instruction loads.
   always_comb begin
      vins_d = vins_q;
      if (!go)                               vins_d = 1'b0;
      else if (romold && (state_q != S_IMM)) vins_d = 1'b1;
      else if (exe)                          vins_d = 1'b0;
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         vins_q   <= 1'b0;
         rem_q    <= 2'd0;
         idx_q    <= 2'd0;
         godrop_q <= 1'b0;
         insexe_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         vins_q   <= vins_d;
         rem_q    <= rem_d;
         idx_q    <= idx_d;
         godrop_q <= godrop_d;
         insexe_q <= exe;
      end
   end

   assign insexe    = insexe_q;
   assign immidx    = idx_q;
   assign idle      = (state_q == S_IDLE);
   assign stop      = (state_q == S_STOP);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_execon_gen.sv
// Bench for execon_gen: a tagged prefetch stream feeds the DUT; a monitor checks
// every execute and immediate write against the program order queued at issue time.
`timescale 1ns/1ps
module tb_execon_gen;
   localparam int NWAIT = 3;
   localparam int IMMW  = 2;
   localparam int SCW   = 4;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_IMM  = 2'd2;

   typedef struct packed {
      logic        is_instr;
      logic [11:0] id;
      logic        immld;
      logic [1:0]  immcnt;
      logic [2:0]  nimm;
      logic [1:0]  idx;
   } word_t;

   logic sys_clk = 1'b0;
   logic reset, go, insrdy, immld, single_step, single_go;
   logic [1:0] immcnt;
   logic [NWAIT-1:0] wait_req;
`ifdef EXECON_STEPCNT_EN
   logic [SCW-1:0] step_cnt;
`endif
   logic romold, exe, insexe, immwri, stop, idle;
   logic [1:0] immidx, dbg_state;

   word_t       pq[$];
   logic [15:0] exp_q[$];
   logic        avail_pat[$];
   word_t       cur;
   word_t       none_w;
   logic        pop_pend = 1'b0;
   logic        rand_avail = 1'b0;
   logic [11:0] next_id = 12'd0;
   logic [15:0] act;
   int          done_cnt = 0;
   int          exp_steps = 1;
   int          total = 0;
   int          bad = 0;

   execon_gen #(.NWAIT(NWAIT), .IMMW(IMMW), .SCW(SCW)) dut (
      .sys_clk(sys_clk), .reset(reset), .go(go), .insrdy(insrdy), .immld(immld),
      .immcnt(immcnt), .wait_req(wait_req), .single_step(single_step), .single_go(single_go),
`ifdef EXECON_STEPCNT_EN
      .step_cnt(step_cnt),
`endif
      .romold(romold), .exe(exe), .insexe(insexe), .immwri(immwri), .immidx(immidx),
      .stop(stop), .idle(idle), .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 sys_clk = ~sys_clk;

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
      total++;
      if (a !== r) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, a, r, $time);
      end
   endtask

   task automatic sb_compare(input string name, input logic [15:0] a);
      logic [15:0] r;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s actual=%h required=<nothing queued> t=%0t", name, a, $time);
      end else begin
         r = exp_q.pop_front();
         if (a !== r) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, a, r, $time);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Pushes one instruction and its extension words, and queues the responses:
   // one execute, then one immediate write per extension word in index order.
   task automatic add_instr(input logic imm, input logic [1:0] cnt);
      word_t w;
      int    n;
      n = imm ? ((int'(cnt) >= IMMW) ? IMMW : int'(cnt) + 1) : 0;
      w = '0;
      w.is_instr = 1'b1;
      w.id       = next_id;
      w.immld    = imm;
      w.immcnt   = cnt;
      w.nimm     = 3'(n);
      pq.push_back(w);
      exp_q.push_back({2'd1, next_id, 2'd0});
      for (int j = 0; j < n; j++) begin
         w.is_instr = 1'b0;
         w.idx      = 2'(j);
         pq.push_back(w);
         exp_q.push_back({2'd2, next_id, 2'(j)});
      end
      next_id = next_id + 12'd1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge sys_clk);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // Prefetch queue model: pops the head on each edge where the DUT consumed it.
   initial begin : feeder
      word_t w;
      logic  av;
      insrdy = 1'b0;
      immld  = 1'b0;
      immcnt = 2'd0;
      forever begin
         @(posedge sys_clk);
         if (pop_pend && pq.size() > 0) begin
            w = pq.pop_front();
            if (w.is_instr) cur = w;
         end
         #1;
         if (avail_pat.size() > 0) av = avail_pat.pop_front();
         else if (rand_avail)      av = ($urandom_range(0, 3) != 0);
         else                      av = 1'b1;
         insrdy = av && (pq.size() > 0);
         immld  = cur.immld;
         immcnt = cur.immcnt;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge sys_clk) begin
      if (reset) begin
         pop_pend = 1'b0;
      end else begin
         pop_pend = romold & insrdy;
         if (romold) check("romold_needs_insrdy", insrdy, 1);
         if (exe) begin
            check("exe_under_wait", 32'(wait_req), 0);
            sb_compare("exe_order", {2'd1, cur.id, 2'd0});
            if (cur.nimm == 3'd0) done_cnt++;
         end
         if (immwri) begin
            check("immwri_consumes", romold, 1);
            if (pq.size() == 0 || pq[0].is_instr) act = {2'd2, 12'hfff, immidx};
            else                                  act = {2'd2, pq[0].id, immidx};
            sb_compare("imm_order", act);
            if (pq.size() > 0 && !pq[0].is_instr && int'(pq[0].idx) == int'(pq[0].nimm) - 1)
               done_cnt++;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      none_w    = '0;
      none_w.id = 12'hffe;
      cur       = none_w;
      reset = 1'b1; go = 1'b0; single_step = 1'b0; single_go = 1'b0; wait_req = '0;
`ifdef EXECON_STEPCNT_EN
      step_cnt = SCW'(3);
`endif
      repeat (2) @(posedge sys_clk);
      #1 go = 1'b1;
      for (int i = 0; i < 6; i++) add_instr(1'b0, 2'd0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_idle", idle, 1);
      check("rst_stop", stop, 0);
      check("rst_romold", romold, 0);
      check("rst_exe", exe, 0);
      check("rst_immwri", immwri, 0);
      check("rst_immidx", immidx, 0);
      check("rst_insexe", insexe, 0);

      // start-up latency from reset release
      @(posedge sys_clk); #1 reset = 1'b0;
      @(negedge sys_clk);
      check("c0_idle", idle, 1);
      check("c0_romold", romold, 0);
      @(negedge sys_clk);
      check("c1_idle", idle, 0);
      check("c1_romold", romold, 1);
      check("c1_exe", exe, 0);
      @(negedge sys_clk);
      check("c2_exe", exe, 1);
      check("c2_insexe", insexe, 0);
      @(negedge sys_clk);
      check("c3_exe", exe, 1);
      check("c3_insexe", insexe, 1);
      drain("drain_startup", 100);

      // immediate sequence with an insrdy gap
      @(negedge sys_clk);
      add_instr(1'b1, 2'd1);
      add_instr(1'b0, 2'd0);
      avail_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      @(negedge sys_clk); check("imm_a_romold", romold, 1);
      @(negedge sys_clk); check("imm_b_exe", exe, 1); check("imm_b_romold", romold, 0);
      @(negedge sys_clk); check("imm_c_wri", immwri, 1); check("imm_c_idx", immidx, 0);
      @(negedge sys_clk); check("imm_d_wri", immwri, 0); check("imm_d_romold", romold, 0);
      @(negedge sys_clk); check("imm_e_wri", immwri, 1); check("imm_e_idx", immidx, 1);
      @(negedge sys_clk); check("imm_f_state", dbg_state, ST_EXEC); check("imm_f_romold", romold, 1);
      drain("drain_imm", 100);

      // wait_req stall
      for (int i = 0; i < 10; i++) add_instr(1'b0, 2'd0);
      repeat (4) @(posedge sys_clk);
      for (int k = 0; k < 3; k++) begin
         #1 wait_req = 3'b010;
         @(negedge sys_clk);
         check("stall_exe", exe, 0);
         check("stall_romold", romold, 0);
         @(posedge sys_clk);
      end
      #1 wait_req = '0;
      @(negedge sys_clk);
      check("stall_resume_exe", exe, 1);
      drain("drain_stall", 100);

      // randomized run
      rand_avail = 1'b1;
      for (int i = 0; i < 40; i++) add_instr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      n = 0;
      while (exp_q.size() > 0 && n < 3000) begin
         @(posedge sys_clk);
         #1 wait_req = ($urandom_range(0, 3) == 0) ? NWAIT'($urandom_range(1, 7)) : '0;
         n++;
      end
      #1 wait_req = '0;
      check("drain_random", exp_q.size(), 0);

      // single-step
      for (int i = 0; i < 30; i++) add_instr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      single_step = 1'b1;
      for (int s = 0; s < 6; s++) begin
         n = 0;
         while (!stop && n < 300) begin @(negedge sys_clk); n++; end
         check("stop_reached", stop, 1);
         if (s > 0) check("steps_per_go", done_cnt, exp_steps);
         if (s == 3) begin
            @(posedge sys_clk); #1 single_step = 1'b0;
            repeat (3) @(negedge sys_clk);
            check("stop_holds", stop, 1);
            @(posedge sys_clk); #1 single_step = 1'b1;
         end
         @(posedge sys_clk);
         #1 single_go = 1'b1;
         done_cnt = 0;
`ifdef EXECON_STEPCNT_EN
         step_cnt  = SCW'($urandom_range(0, 3));
         exp_steps = (step_cnt == '0) ? 1 : int'(step_cnt);
`else
         exp_steps = 1;
`endif
         @(posedge sys_clk);
         #1 single_go = 1'b0;
      end
      n = 0;
      while (!stop && n < 300) begin @(negedge sys_clk); n++; end
      check("stop_last", stop, 1);
      @(posedge sys_clk); #1 single_step = 1'b0; single_go = 1'b1;
      @(posedge sys_clk); #1 single_go = 1'b0;
      drain("drain_step", 600);
      check("run_after_step", stop, 0);

      // go dropped with two extension words pending (immcnt=2 clamps to two words)
      rand_avail = 1'b0;
      @(negedge sys_clk);
      add_instr(1'b1, 2'd2);
      add_instr(1'b0, 2'd0);
      avail_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      @(negedge sys_clk); check("gd_a_romold", romold, 1);
      @(negedge sys_clk); check("gd_b_exe", exe, 1);
      @(posedge sys_clk); #1 go = 1'b0;
      @(negedge sys_clk); check("gd_c_wri", immwri, 0); check("gd_c_state", dbg_state, ST_IMM);
      @(negedge sys_clk); check("gd_d_wri", immwri, 1); check("gd_d_idx", immidx, 0);
      @(negedge sys_clk); check("gd_e_wri", immwri, 1); check("gd_e_idx", immidx, 1);
      @(negedge sys_clk); check("gd_f_idle", idle, 1); check("gd_f_romold", romold, 0);
      @(posedge sys_clk); #1 go = 1'b1;
      drain("drain_godrop", 100);

      // asynchronous reset in the middle of an immediate sequence
      @(negedge sys_clk);
      add_instr(1'b1, 2'd3);
      add_instr(1'b0, 2'd0);
      @(negedge sys_clk); check("rm_a_romold", romold, 1);
      @(negedge sys_clk); check("rm_b_exe", exe, 1);
      @(negedge sys_clk); check("rm_c_wri", immwri, 1); check("rm_c_idx", immidx, 0);
      @(posedge sys_clk); #2 reset = 1'b1;
      #1;
      check("rm_idle", idle, 1);
      check("rm_immwri", immwri, 0);
      check("rm_immidx", immidx, 0);
      check("rm_romold", romold, 0);
      pq.delete();
      exp_q.delete();
      avail_pat.delete();
      cur = none_w;
      @(posedge sys_clk); #1 reset = 1'b0;
      add_instr(1'b0, 2'd0);
      drain("drain_after_reset", 50);

      // wait_req and go=0 together
      @(negedge sys_clk);
      for (int i = 0; i < 4; i++) add_instr(1'b0, 2'd0);
      repeat (3) @(posedge sys_clk);
      #1 wait_req = 3'b100; go = 1'b0;
      @(negedge sys_clk); check("gw_exe", exe, 0); check("gw_romold", romold, 0);
      @(negedge sys_clk); check("gw_idle", idle, 1);
      wait_req = '0;
      exp_q.delete();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
